fu_op_sequencer: RTL and testbench
==================================

Name: fu_op_sequencer

Overview:
- Command sequencer and operand register file that sits directly upstream of the 8-bit functional unit.
- Buffers exec commands in a small FIFO and owns the three 8-bit operand registers (A, B, C).
- Issues one command at a time, driving a one-hot instruction, the operands and the operand select to the functional unit.
- Captures the unit's combinational result F and writes it back to a destination operand register, so chained ops can run without host involvement.

Parameters:
DEPTH, 4, command FIFO entries; power of two, 2..16
PTR_W, 2, FIFO pointer width, log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
ld_en  input  1  operand load strobe; honoured only when ld_ready=1
ld_addr  input  2  load target: 0=A, 1=B, 2=C, 3=ignored
ld_data  input  8  load value
ld_ready  output  1  1 when state=IDLE and FIFO empty
cmd_valid  input  1  exec command present
cmd_ready  output  1  1 when FIFO not full
cmd_opcode  input  3  binary op index 0..7
cmd_select  input  3  operand pair select, passed through unchanged
cmd_dest  input  2  writeback target: 0=A, 1=B, 2=C, 3=none (result port only)
fu_instruction  output  8  one-hot instruction to functional unit
fu_a  output  8  register A
fu_b  output  8  register B
fu_c  output  8  register C
fu_select  output  3  select of the issuing command
fu_f  input  8  functional-unit result (combinational from outputs above)
res_valid  output  1  one-cycle pulse per completed command
res_data  output  8  captured result, held until next completion
res_dest  output  2  cmd_dest of the completed command
busy  output  1  1 when state!=IDLE or FIFO non-empty

Behaviour:
- Reset, asynchronous and immediate:
  - A=B=C=0; FIFO emptied with pointers and count at 0; state=IDLE.
  - res_valid=0, res_data=0, res_dest=0, fu_instruction=8'h00, fu_select=0.
  - A command in flight is dropped with no res_valid.
- FIFO:
  - Push when cmd_valid & cmd_ready; cmd_ready = !full, independent of a same-cycle pop.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Command order is strictly preserved.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the issue register and go to ISSUE.
  - ISSUE: lasts exactly one cycle.
    - fu_instruction = 8'h01 << opcode, registered; fu_select = issued select.
    - At the closing edge: res_data <= fu_f, res_dest <= dest, write fu_f into reg[dest] if dest != 3, then go to WB.
  - WB: res_valid=1 for exactly this cycle.
    - If the FIFO is non-empty, pop the head and go to ISSUE (back-to-back); otherwise go to IDLE.
- Outputs outside ISSUE:
  - fu_instruction = 8'h00.
  - fu_select holds its last value.
- Timing:
  - A command pushed at edge t into an empty FIFO while IDLE is popped at t+1 (ISSUE during t+1..t+2).
  - Writeback occurs at t+2; res_valid is high during t+2..t+3.
  - Sustained throughput is one command per 2 cycles.
- Hazards: writeback completes before the next ISSUE, so a dependent command sees the updated register with no forwarding.
- Loads:
  - Write reg[ld_addr] at the edge when ld_en & ld_ready; ld_addr=3 has no effect.
  - ld_en while ld_ready=0 is ignored; it is not queued.
  - Loads can never collide with writeback.
- Arithmetic: no arithmetic is performed here; fu_f is captured verbatim, 8 bits, with no width extension.

Optional Feature:
- Macro: FU_SEQ_ZFLAG_EN.
- When defined, two extra outputs are present:
  - res_zero (1 bit): registered with res_data, 1 when the captured fu_f == 8'h00.
  - zero_cnt (8 bits): saturating count of completions with res_zero=1; saturates at 8'hFF; cleared by rst.
- When undefined, both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then load A=8'h12, B=8'h34; push cmd opcode=0, select=3'b110, dest=2.
  - ISSUE cycle shows fu_instruction=8'h01, fu_select=3'b110.
  - res_valid pulses once with res_data=8'h46, res_dest=2; C reads 8'h46.
- Chained ops: A=8'h0F, B=8'hF0; push {op=3, sel=110, dest=0} then {op=2, sel=110, dest=3}.
  - First result: A=8'hFF.
  - Second result: res_data=8'hF0, with no register change.
  - The two res_valid pulses are exactly 2 cycles apart.
- FIFO full: hold cmd_valid with DEPTH+2 commands while blocking issue via back-to-back pushes.
  - cmd_ready drops when count reaches DEPTH.
  - Every accepted command completes in order; the count of res_valid pulses equals the count of accepted commands.
- Load lockout: assert ld_en with ld_addr=0, ld_data=8'h55 while busy=1.
  - A is unchanged.
  - The same load after busy=0 sets A=8'h55.
- Reset mid-op: assert rst during an ISSUE cycle with 2 entries queued.
  - All outputs return to reset values immediately; no res_valid follows.
  - busy=0 and cmd_ready=1 after release.
- With FU_SEQ_ZFLAG_EN: A=B=0, push opcode=0, sel=110, dest=3 three times.
  - res_zero=1 on each completion; zero_cnt=3.

Source files
------------

// File: rtl/fu_op_sequencer.sv
// fu_op_sequencer: command FIFO + operand register file in front of the 8-bit
// functional unit. Issues one command at a time (IDLE -> ISSUE -> WB), captures
// the unit's combinational result and writes it back to A/B/C.
// Optional build macro FU_SEQ_ZFLAG_EN adds res_zero and a saturating zero_cnt.
module fu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_opcode,
  input  logic [2:0] cmd_select,
  input  logic [1:0] cmd_dest,
  output logic [7:0] fu_instruction,
  output logic [7:0] fu_a,
  output logic [7:0] fu_b,
  output logic [7:0] fu_c,
  output logic [2:0] fu_select,
  input  logic [7:0] fu_f,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic [1:0] res_dest,
  output logic       busy
`ifdef FU_SEQ_ZFLAG_EN
  ,
  output logic       res_zero,
  output logic [7:0] zero_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] sel;
    logic [1:0] dest;
  } cmd_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_t           state;
  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [1:0]       iss_dest;
  logic [7:0]       reg_a, reg_b, reg_c;
  logic             push, pop;

  assign head      = mem[rd_ptr];
  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid & cmd_ready;
  // Pops happen only from IDLE or WB, so a popped command always gets a full ISSUE cycle.
  assign pop       = ((state == S_IDLE) || (state == S_WB)) && (count != '0);
  assign ld_ready  = (state == S_IDLE) && (count == '0);
  assign busy      = (state != S_IDLE) || (count != '0);
  assign fu_a      = reg_a;
  assign fu_b      = reg_b;
  assign fu_c      = reg_c;

  // Command storage; contents need no reset since pointers/count gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: cmd_opcode, sel: cmd_select, dest: cmd_dest};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH == 2**PTR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue FSM with registered outputs, result capture and the operand registers.
  // Loads need ld_ready (IDLE), writeback only happens leaving ISSUE, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      fu_instruction <= 8'h00;
      fu_select      <= 3'd0;
      iss_dest       <= 2'd0;
      res_valid      <= 1'b0;
      res_data       <= 8'h00;
      res_dest       <= 2'd0;
      reg_a          <= 8'h00;
      reg_b          <= 8'h00;
      reg_c          <= 8'h00;
    end else begin
      res_valid      <= 1'b0;
      fu_instruction <= 8'h00;
      case (state)
        S_IDLE, S_WB: begin
          if (pop) begin
            state          <= S_ISSUE;
            fu_instruction <= 8'h01 << head.op;
            fu_select      <= head.sel;
            iss_dest       <= head.dest;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          state     <= S_WB;
          res_valid <= 1'b1;
          res_data  <= fu_f;
          res_dest  <= iss_dest;
          case (iss_dest)
            2'd0:    reg_a <= fu_f;
            2'd1:    reg_b <= fu_f;
            2'd2:    reg_c <= fu_f;
            default: ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
      if (ld_en && ld_ready) begin
        case (ld_addr)
          2'd0:    reg_a <= ld_data;
          2'd1:    reg_b <= ld_data;
          2'd2:    reg_c <= ld_data;
          default: ;
        endcase
      end
    end
  end

`ifdef FU_SEQ_ZFLAG_EN
  // Zero flag captured alongside res_data; zero_cnt saturates at 8'hFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_zero <= 1'b0;
      zero_cnt <= 8'h00;
    end else if (state == S_ISSUE) begin
      res_zero <= (fu_f == 8'h00);
      if ((fu_f == 8'h00) && (zero_cnt != 8'hFF)) zero_cnt <= zero_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_fu_op_sequencer.sv
// Directed bench for fu_op_sequencer: table of single-command vectors plus
// hand-written sequences (chaining, FIFO full, load lockout, reset mid-op).
// A small functional-unit model drives fu_f from the DUT's outputs.
module tb_fu_op_sequencer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_en = 1'b0;
  logic [1:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       ld_ready;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_opcode = '0;
  logic [2:0] cmd_select = '0;
  logic [1:0] cmd_dest = '0;
  logic [7:0] fu_instruction, fu_a, fu_b, fu_c;
  logic [2:0] fu_select;
  logic [7:0] fu_f;
  logic       res_valid;
  logic [7:0] res_data;
  logic [1:0] res_dest;
  logic       busy;
`ifdef FU_SEQ_ZFLAG_EN
  logic       res_zero;
  logic [7:0] zero_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fu_op_sequencer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_select(cmd_select), .cmd_dest(cmd_dest),
    .fu_instruction(fu_instruction), .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c),
    .fu_select(fu_select), .fu_f(fu_f),
    .res_valid(res_valid), .res_data(res_data), .res_dest(res_dest), .busy(busy)
`ifdef FU_SEQ_ZFLAG_EN
    , .res_zero(res_zero), .zero_cnt(zero_cnt)
`endif
  );

  // Functional-unit model: one-hot instruction selects the operation.
  function automatic logic [7:0] fu_model(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b);
    case (ins)
      8'h01:   return a + b;
      8'h02:   return a - b;
      8'h04:   return a & b;
      8'h08:   return a | b;
      8'h10:   return a ^ b;
      8'h20:   return ~a;
      8'h40:   return a;
      8'h80:   return b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb fu_f = fu_model(fu_instruction, fu_a, fu_b);

  // Cycle counter and result/issue monitor, sampled on the falling edge.
  int         cyc = 0;
  logic [7:0] r_data[$];
  logic [1:0] r_dest[$];
  int         r_cyc[$];
  logic       r_zero[$];
  logic [7:0] last_instr = 8'h00;
  logic [2:0] last_sel = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fu_instruction != 8'h00) begin
      last_instr <= fu_instruction;
      last_sel   <= fu_select;
    end
    if (res_valid) begin
      r_data.push_back(res_data);
      r_dest.push_back(res_dest);
      r_cyc.push_back(cyc);
`ifdef FU_SEQ_ZFLAG_EN
      r_zero.push_back(res_zero);
`else
      r_zero.push_back(1'b0);
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic push(input logic [2:0] op, input logic [2:0] sel, input logic [1:0] dest, output int pc);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_select = sel; cmd_dest = dest;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    pc = cyc;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check({"idle_timeout_", name}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [7:0] a, b, c;
    logic [2:0] op, sel;
    logic [1:0] dest;
    logic [7:0] exp_f, exp_a, exp_b, exp_c;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] full_exp[10];

  initial begin
    int pc, n0, acc, first_block, guard;
    logic rdy;
    logic [7:0] one;

    vecs[0] = '{8'h12, 8'h34, 8'h00, 3'd0, 3'b110, 2'd2, 8'h46, 8'h12, 8'h34, 8'h46};
    vecs[1] = '{8'h0F, 8'hF0, 8'h77, 3'd3, 3'b110, 2'd0, 8'hFF, 8'hFF, 8'hF0, 8'h77};
    vecs[2] = '{8'hFF, 8'hF0, 8'h77, 3'd2, 3'b110, 2'd3, 8'hF0, 8'hFF, 8'hF0, 8'h77};
    vecs[3] = '{8'h80, 8'h80, 8'h11, 3'd0, 3'b001, 2'd1, 8'h00, 8'h80, 8'h00, 8'h11};
    vecs[4] = '{8'h05, 8'h07, 8'h00, 3'd1, 3'b010, 2'd2, 8'hFE, 8'h05, 8'h07, 8'hFE};
    vecs[5] = '{8'hAA, 8'h0F, 8'h33, 3'd4, 3'b101, 2'd0, 8'hA5, 8'hA5, 8'h0F, 8'h33};
    vecs[6] = '{8'h3C, 8'h00, 8'h44, 3'd5, 3'b111, 2'd1, 8'hC3, 8'h3C, 8'hC3, 8'h44};
    vecs[7] = '{8'h01, 8'h9E, 8'h00, 3'd7, 3'b000, 2'd2, 8'h9E, 8'h01, 8'h9E, 8'h9E};
    full_exp = '{8'h24, 8'h1E, 8'h01, 8'h23, 8'h22, 8'hDE, 8'h21, 8'h03, 8'h24, 8'h1E};
    one = 8'h01;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", 32'(fu_instruction), 32'h00);
    check("rst_a", 32'(fu_a), 32'h00);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    rst = 1'b0;

    // Table-driven single commands
    for (int v = 0; v < 8; v++) begin
      wait_idle(20, "pre");
      @(posedge clk); #1;
      do_load(2'd0, vecs[v].a);
      do_load(2'd1, vecs[v].b);
      do_load(2'd2, vecs[v].c);
      n0 = r_data.size();
      push(vecs[v].op, vecs[v].sel, vecs[v].dest, pc);
      wait_idle(20, $sformatf("v%0d", v));
      check($sformatf("v%0d_count", v), 32'(r_data.size()), 32'(n0 + 1));
      if (r_data.size() == n0 + 1) begin
        check($sformatf("v%0d_data", v), 32'(r_data[n0]), 32'(vecs[v].exp_f));
        check($sformatf("v%0d_dest", v), 32'(r_dest[n0]), 32'(vecs[v].dest));
        check($sformatf("v%0d_latency", v), 32'(r_cyc[n0] - pc), 32'd2);
      end
      check($sformatf("v%0d_instr", v), 32'(last_instr), 32'(one << vecs[v].op));
      check($sformatf("v%0d_sel", v), 32'(last_sel), 32'(vecs[v].sel));
      check($sformatf("v%0d_a", v), 32'(fu_a), 32'(vecs[v].exp_a));
      check($sformatf("v%0d_b", v), 32'(fu_b), 32'(vecs[v].exp_b));
      check($sformatf("v%0d_c", v), 32'(fu_c), 32'(vecs[v].exp_c));
    end

    // Chained ops, back-to-back pushes
    @(posedge clk); #1;
    do_load(2'd0, 8'h0F);
    do_load(2'd1, 8'hF0);
    n0 = r_data.size();
    push(3'd3, 3'b110, 2'd0, pc);
    push(3'd2, 3'b110, 2'd3, pc);
    wait_idle(30, "chain");
    check("chain_count", 32'(r_data.size()), 32'(n0 + 2));
    if (r_data.size() == n0 + 2) begin
      check("chain_r0_data", 32'(r_data[n0]), 32'hFF);
      check("chain_r0_dest", 32'(r_dest[n0]), 32'd0);
      check("chain_r1_data", 32'(r_data[n0+1]), 32'hF0);
      check("chain_r1_dest", 32'(r_dest[n0+1]), 32'd3);
      check("chain_gap", 32'(r_cyc[n0+1] - r_cyc[n0]), 32'd2);
    end
    check("chain_a", 32'(fu_a), 32'hFF);
    check("chain_b", 32'(fu_b), 32'hF0);

    // FIFO full: push faster than the 1-per-2-cycle drain
    @(posedge clk); #1;
    do_load(2'd0, 8'h21);
    do_load(2'd1, 8'h03);
    n0 = r_data.size();
    acc = 0; first_block = -1; guard = 0;
    while (acc < 10 && guard < 100) begin
      cmd_valid = 1'b1; cmd_opcode = 3'(acc % 8); cmd_select = 3'(acc); cmd_dest = 2'd3;
      rdy = cmd_ready;
      if (!rdy && first_block < 0) first_block = acc;
      @(posedge clk); #1;
      if (rdy) acc++;
      guard++;
    end
    cmd_valid = 1'b0;
    check("full_accepted", 32'(acc), 32'd10);
    check("full_first_block", 32'(first_block), 32'd7);
    wait_idle(80, "full");
    check("full_count", 32'(r_data.size()), 32'(n0 + 10));
    if (r_data.size() == n0 + 10) begin
      for (int k = 0; k < 10; k++)
        check($sformatf("full_r%0d", k), 32'(r_data[n0+k]), 32'(full_exp[k]));
      check("full_span", 32'(r_cyc[n0+9] - r_cyc[n0]), 32'd18);
    end
    check("full_a_kept", 32'(fu_a), 32'h21);

    // Load lockout while busy
    @(posedge clk); #1;
    do_load(2'd0, 8'h11);
    push(3'd6, 3'b000, 2'd3, pc);
    check("lock_busy", 32'(busy), 32'd1);
    check("lock_ld_ready", 32'(ld_ready), 32'd0);
    do_load(2'd0, 8'h55);
    wait_idle(20, "lock");
    check("lock_a_unchanged", 32'(fu_a), 32'h11);
    @(posedge clk); #1;
    do_load(2'd0, 8'h55);
    check("lock_a_loaded", 32'(fu_a), 32'h55);

    // Reset during ISSUE with two entries queued
    do_load(2'd0, 8'h01);
    do_load(2'd1, 8'h02);
    for (int k = 0; k < 4; k++) push(3'd0, 3'b110, 2'd0, pc);
    check("rmid_in_issue", 32'(fu_instruction), 32'h01);
    check("rmid_busy_pre", 32'(busy), 32'd1);
    n0 = r_data.size();
    #2 rst = 1'b1;
    #1;
    check("rmid_instr", 32'(fu_instruction), 32'h00);
    check("rmid_sel", 32'(fu_select), 32'd0);
    check("rmid_a", 32'(fu_a), 32'h00);
    check("rmid_b", 32'(fu_b), 32'h00);
    check("rmid_res_data", 32'(res_data), 32'h00);
    check("rmid_res_dest", 32'(res_dest), 32'd0);
    check("rmid_res_valid", 32'(res_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rmid_no_result", 32'(r_data.size()), 32'(n0));
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rmid_ld_ready", 32'(ld_ready), 32'd1);

`ifdef FU_SEQ_ZFLAG_EN
    // Zero flag and counter
    check("z_cnt_rst", 32'(zero_cnt), 32'd0);
    do_load(2'd0, 8'h00);
    do_load(2'd1, 8'h00);
    n0 = r_data.size();
    for (int k = 0; k < 3; k++) push(3'd0, 3'b110, 2'd3, pc);
    wait_idle(30, "zflag");
    check("z_count", 32'(r_data.size()), 32'(n0 + 3));
    if (r_data.size() == n0 + 3)
      for (int k = 0; k < 3; k++) check($sformatf("z_flag%0d", k), 32'(r_zero[n0+k]), 32'd1);
    check("z_cnt", 32'(zero_cnt), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
